// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types used by the operand-fetch stage.
package cpu_pkg;

  localparam int unsigned WORD_SIZE   = 32;
  localparam int unsigned INDEX_WIDTH = 4;
  localparam int unsigned OP_WIDTH    = 6;
  localparam int unsigned IMM_WIDTH   = 16;

  typedef struct packed {
    logic [OP_WIDTH-1:0]    op;
    logic [IMM_WIDTH-1:0]   imm;
    logic [INDEX_WIDTH-1:0] rs1;
    logic [INDEX_WIDTH-1:0] rs2;
    logic                   use1;
    logic                   use2;
    logic [INDEX_WIDTH-1:0] rd;
    logic                   wr;
  } dec_instr_t;

  typedef struct packed {
    logic                   valid;
    logic                   wrtEn;
    logic [INDEX_WIDTH-1:0] regno;
    logic [WORD_SIZE-1:0]   data;
  } bypass_src_t;

endpackage

// File: rtl/bypass_mux.sv
// Single-operand forwarding select: execute result, then writeback data, then regfile.
module bypass_mux
  import cpu_pkg::*;
(
  input  logic        use_src,
  input  logic [INDEX_WIDTH-1:0] rs,
  input  bypass_src_t ex_src,
  input  logic        ex_is_load,
  input  bypass_src_t wb_src,
  input  logic [WORD_SIZE-1:0] rf_data,
  output logic [WORD_SIZE-1:0] data
);

  logic ex_hit;
  logic wb_hit;

  // A load in execute has no result yet; the stall logic covers that case.
  assign ex_hit = use_src & ex_src.valid & ex_src.wrtEn & !ex_is_load & (ex_src.regno == rs);
  assign wb_hit = use_src & wb_src.wrtEn & (wb_src.regno == rs);

  always_comb begin
    data = rf_data;
    if (ex_hit)
      data = ex_src.data;
    else if (wb_hit)
      data = wb_src.data;
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute stage: regfile read, EX/WB forwarding, load-use stall, output register.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_WIDTH-1:0]    in_op,
  input  logic [IMM_WIDTH-1:0]   in_imm,
  input  logic [INDEX_WIDTH-1:0] in_rs1,
  input  logic [INDEX_WIDTH-1:0] in_rs2,
  input  logic                   in_use1,
  input  logic                   in_use2,
  input  logic [INDEX_WIDTH-1:0] in_rd,
  input  logic                   in_wr,
  output logic [INDEX_WIDTH-1:0] rf_regno1,
  output logic [INDEX_WIDTH-1:0] rf_regno2,
  input  logic [WORD_SIZE-1:0]   rf_data1,
  input  logic [WORD_SIZE-1:0]   rf_data2,
  input  logic                   ex_valid,
  input  logic                   ex_wrtEn,
  input  logic [INDEX_WIDTH-1:0] ex_wrtRegno,
  input  logic [WORD_SIZE-1:0]   ex_result,
  input  logic                   ex_is_load,
  input  logic                   wb_wrtEn,
  input  logic [INDEX_WIDTH-1:0] wb_wrtRegno,
  input  logic [WORD_SIZE-1:0]   wb_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OP_WIDTH-1:0]    out_op,
  output logic [IMM_WIDTH-1:0]   out_imm,
  output logic [INDEX_WIDTH-1:0] out_rd,
  output logic                   out_wr,
  output logic [WORD_SIZE-1:0]   out_a,
  output logic [WORD_SIZE-1:0]   out_b
);

  dec_instr_t           dec;
  bypass_src_t          ex_src;
  bypass_src_t          wb_src;
  logic [WORD_SIZE-1:0] opnd_a;
  logic [WORD_SIZE-1:0] opnd_b;
  logic                 hz;
  logic                 slot_free;
  logic                 take;

  assign dec = '{op: in_op, imm: in_imm, rs1: in_rs1, rs2: in_rs2,
                 use1: in_use1, use2: in_use2, rd: in_rd, wr: in_wr};

  assign ex_src = '{valid: ex_valid, wrtEn: ex_wrtEn, regno: ex_wrtRegno, data: ex_result};
  assign wb_src = '{valid: 1'b1, wrtEn: wb_wrtEn, regno: wb_wrtRegno, data: wb_data};

  assign rf_regno1 = dec.rs1;
  assign rf_regno2 = dec.rs2;

  bypass_mux u_byp_a (
    .use_src    (dec.use1),
    .rs         (dec.rs1),
    .ex_src     (ex_src),
    .ex_is_load (ex_is_load),
    .wb_src     (wb_src),
    .rf_data    (rf_data1),
    .data       (opnd_a)
  );

  bypass_mux u_byp_b (
    .use_src    (dec.use2),
    .rs         (dec.rs2),
    .ex_src     (ex_src),
    .ex_is_load (ex_is_load),
    .wb_src     (wb_src),
    .rf_data    (rf_data2),
    .data       (opnd_b)
  );

  assign hz = in_valid & ex_valid & ex_wrtEn & ex_is_load &
              ((dec.use1 & (dec.rs1 == ex_wrtRegno)) |
               (dec.use2 & (dec.rs2 == ex_wrtRegno)));

  assign slot_free = !out_valid | out_ready;
  assign in_ready  = slot_free & !hz;
  assign take      = in_valid & in_ready & !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_imm   <= '0;
      out_rd    <= '0;
      out_wr    <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (slot_free) begin
      out_valid <= in_valid & !hz;
      if (take) begin
        out_op  <= dec.op;
        out_imm <= dec.imm;
        out_rd  <= dec.rd;
        out_wr  <= dec.wr;
        out_a   <= opnd_a;
        out_b   <= opnd_b;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch: forwarding priority, load-use stall, backpressure, flush, reset.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [5:0]  in_op;
  logic [15:0] in_imm;
  logic [3:0]  in_rs1, in_rs2, in_rd;
  logic        in_use1, in_use2, in_wr;
  logic [3:0]  rf_regno1, rf_regno2;
  logic [31:0] rf_data1, rf_data2;
  logic        ex_valid, ex_wrtEn, ex_is_load;
  logic [3:0]  ex_wrtRegno;
  logic [31:0] ex_result;
  logic        wb_wrtEn;
  logic [3:0]  wb_wrtRegno;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [5:0]  out_op;
  logic [15:0] out_imm;
  logic [3:0]  out_rd;
  logic        out_wr;
  logic [31:0] out_a, out_b;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use1(in_use1), .in_use2(in_use2),
    .in_rd(in_rd), .in_wr(in_wr),
    .rf_regno1(rf_regno1), .rf_regno2(rf_regno2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_valid(ex_valid), .ex_wrtEn(ex_wrtEn), .ex_wrtRegno(ex_wrtRegno),
    .ex_result(ex_result), .ex_is_load(ex_is_load),
    .wb_wrtEn(wb_wrtEn), .wb_wrtRegno(wb_wrtRegno), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_imm(out_imm), .out_rd(out_rd), .out_wr(out_wr),
    .out_a(out_a), .out_b(out_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b1; in_op = 6'd0; in_imm = 16'd0;
    in_rs1 = 4'd0; in_rs2 = 4'd0; in_use1 = 1'b1; in_use2 = 1'b1;
    in_rd = 4'd0; in_wr = 1'b0; rf_data1 = 32'h1; rf_data2 = 32'h2;
    ex_valid = 1'b0; ex_wrtEn = 1'b0; ex_wrtRegno = 4'd0; ex_result = '0; ex_is_load = 1'b0;
    wb_wrtEn = 1'b0; wb_wrtRegno = 4'd0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;

    // Reset held with a valid instruction present.
    step(); step();
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_out_a", out_a, 32'h0);
    check("reset_out_op", {26'b0, out_op}, 32'h0);

    // Plain regfile read.
    reset = 1'b1;
    in_rs1 = 4'd3; in_rs2 = 4'd5; rf_data1 = 32'h11; rf_data2 = 32'h22;
    in_op = 6'd5; in_imm = 16'h1234; in_rd = 4'd9; in_wr = 1'b1;
    #1;
    check("plain_in_ready", {31'b0, in_ready}, 32'h1);
    check("rf_regno1", {28'b0, rf_regno1}, 32'h3);
    check("rf_regno2", {28'b0, rf_regno2}, 32'h5);
    step();
    check("plain_out_valid", {31'b0, out_valid}, 32'h1);
    check("plain_out_a", out_a, 32'h11);
    check("plain_out_b", out_b, 32'h22);
    check("plain_out_op", {26'b0, out_op}, 32'h5);
    check("plain_out_imm", {16'b0, out_imm}, 32'h1234);
    check("plain_out_rd", {28'b0, out_rd}, 32'h9);
    check("plain_out_wr", {31'b0, out_wr}, 32'h1);

    // EX beats WB.
    in_rs1 = 4'd7; rf_data1 = 32'h0;
    ex_valid = 1'b1; ex_wrtEn = 1'b1; ex_wrtRegno = 4'd7; ex_result = 32'hAAAA;
    wb_wrtEn = 1'b1; wb_wrtRegno = 4'd7; wb_data = 32'hBBBB;
    step();
    check("prio_ex_a", out_a, 32'hAAAA);
    check("prio_ex_b", out_b, 32'h22);

    // WB only.
    ex_valid = 1'b0;
    step();
    check("prio_wb_a", out_a, 32'hBBBB);

    // Same source on both operands, forwarded from EX.
    wb_wrtEn = 1'b0;
    in_rs1 = 4'd6; in_rs2 = 4'd6; rf_data1 = 32'h1; rf_data2 = 32'h2;
    ex_valid = 1'b1; ex_wrtRegno = 4'd6; ex_result = 32'hCC;
    step();
    check("same_src_a", out_a, 32'hCC);
    check("same_src_b", out_b, 32'hCC);

    // Unused operand ignores a matching EX producer.
    in_use1 = 1'b0;
    step();
    check("unused_a_rf", out_a, 32'h1);
    check("used_b_ex", out_b, 32'hCC);
    in_use1 = 1'b1;

    // Load-use stall on rs2.
    in_rs1 = 4'd3; rf_data1 = 32'h11; in_rs2 = 4'd4; rf_data2 = 32'h0;
    ex_valid = 1'b1; ex_wrtEn = 1'b1; ex_wrtRegno = 4'd4; ex_is_load = 1'b1; ex_result = 32'hDEAD;
    #1;
    check("lu_in_ready", {31'b0, in_ready}, 32'h0);
    step();
    check("lu_bubble", {31'b0, out_valid}, 32'h0);
    check("lu_in_ready2", {31'b0, in_ready}, 32'h0);
    step();
    check("lu_bubble2", {31'b0, out_valid}, 32'h0);

    // Load data now arrives on the writeback port.
    ex_valid = 1'b0; ex_is_load = 1'b0;
    wb_wrtEn = 1'b1; wb_wrtRegno = 4'd4; wb_data = 32'h55;
    #1;
    check("lu_release_ready", {31'b0, in_ready}, 32'h1);
    step();
    check("lu_release_valid", {31'b0, out_valid}, 32'h1);
    check("lu_release_a", out_a, 32'h11);
    check("lu_release_b", out_b, 32'h55);

    // Matching load in EX, but rs2 unused: no stall.
    wb_wrtEn = 1'b0;
    ex_valid = 1'b1; ex_is_load = 1'b1; in_use2 = 1'b0; rf_data2 = 32'h66;
    #1;
    check("nolu_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    check("nolu_out_valid", {31'b0, out_valid}, 32'h1);
    check("nolu_out_b", out_b, 32'h66);

    // Backpressure: outputs frozen while inputs change.
    ex_valid = 1'b0; ex_is_load = 1'b0; in_use2 = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_rs1 = 4'(i + 1); rf_data1 = 32'h90 + 32'(i); rf_data2 = 32'hA0 + 32'(i);
      in_op = 6'(20 + i);
      wb_wrtEn = 1'b1; wb_wrtRegno = in_rs1; wb_data = 32'hF0 + 32'(i);
      #1;
      check("bp_in_ready", {31'b0, in_ready}, 32'h0);
      step();
      check("bp_out_valid", {31'b0, out_valid}, 32'h1);
      check("bp_out_a", out_a, 32'h11);
      check("bp_out_b", out_b, 32'h66);
      check("bp_out_op", {26'b0, out_op}, 32'h5);
    end

    wb_wrtEn = 1'b0; out_ready = 1'b1;
    in_rs1 = 4'd1; in_rs2 = 4'd2; rf_data1 = 32'h77; rf_data2 = 32'h88; in_op = 6'd33;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'h1);
    step();
    check("bp_release_a", out_a, 32'h77);
    check("bp_release_b", out_b, 32'h88);
    check("bp_release_op", {26'b0, out_op}, 32'd33);

    // Flush overrides an accept.
    flush = 1'b1;
    #1;
    check("flush_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    check("flush_out_valid", {31'b0, out_valid}, 32'h0);
    flush = 1'b0;
    rf_data1 = 32'h123;
    step();
    check("post_flush_valid", {31'b0, out_valid}, 32'h1);
    check("post_flush_a", out_a, 32'h123);

    // Async reset in the middle of a hold, between clock edges.
    out_ready = 1'b0;
    step();
    check("hold_valid", {31'b0, out_valid}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'h0);
    check("async_rst_a", out_a, 32'h0);
    check("async_rst_b", out_b, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode→execute pipeline stage wrapped around the register file's two combinational read ports.
- Drives read indices to the regfile.
- Resolves RAW hazards by bypassing from execute and writeback, and stalls on load-use.
- Captures operands and control into a valid/ready output register that feeds the execute stage.

Parameters:
WORD_SIZE, 32, operand/data width (matches regfile)
INDEX_WIDTH, 4, register index width (16 registers, no hardwired zero)
OP_WIDTH, 6, opaque decoded-op field width, passed through
IMM_WIDTH, 16, immediate width, passed through unchanged

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
in_valid  input  1  decoded instruction present
in_ready  output  1  stage accepts instruction this cycle
in_op  input  OP_WIDTH  decoded op
in_imm  input  IMM_WIDTH  immediate
in_rs1/in_rs2  input  INDEX_WIDTH  source indices
in_use1/in_use2  input  1  source actually read (gates hazard/bypass)
in_rd  input  INDEX_WIDTH  destination index
in_wr  input  1  instruction writes rd
rf_regno1/rf_regno2  output  INDEX_WIDTH  regfile read indices (= in_rs1/in_rs2, combinational)
rf_data1/rf_data2  input  WORD_SIZE  regfile read data
ex_valid  input  1  execute stage holds an instruction
ex_wrtEn  input  1  execute instruction writes a register
ex_wrtRegno  input  INDEX_WIDTH  execute destination
ex_result  input  WORD_SIZE  execute ALU result
ex_is_load  input  1  execute result not yet available (memory load)
wb_wrtEn/wb_wrtRegno/wb_data  input  1/INDEX_WIDTH/WORD_SIZE  same signals as the regfile write port
flush  input  1  squash stage contents (branch redirect)
out_valid  output  1  registered instruction valid to execute
out_ready  input  1  execute accepts
out_op, out_imm, out_rd, out_wr  output  widths as inputs  registered pass-through
out_a/out_b  output  WORD_SIZE  registered resolved operands

Behaviour:
- Reset (async, reset=0): out_valid=0; all out_* payload = 0. Release is synchronous to clk.
- Operand selection, per source n, priority order:
  - EX: ex_valid & ex_wrtEn & !ex_is_load & ex_wrtRegno==in_rsn → ex_result
  - else WB: wb_wrtEn & wb_wrtRegno==in_rsn → wb_data. The regfile write lands at this edge, so its read returns the old value.
  - else rf_datan.
  - Bypass applies only if in_usen=1; an unused operand takes rf_datan.
- Load-use stall: hz = in_valid & ex_valid & ex_wrtEn & ex_is_load & ((in_use1 & in_rs1==ex_wrtRegno) | (in_use2 & in_rs2==ex_wrtRegno)).
- in_ready = (!out_valid | out_ready) & !hz. Combinational; does not depend on in_valid except through hz.
- Clock edge update:
  - flush=1 → out_valid←0; payload don't-care; input is not consumed. Flush wins over accept, stall and hold.
  - else if (!out_valid | out_ready) → out_valid←in_valid & !hz. On accept, payload and out_a/out_b are loaded with the resolved values.
  - else hold: all outputs unchanged.
- A stall inserts a bubble (out_valid=0) when the output slot drains. The instruction is re-evaluated every cycle until hz clears.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 per cycle with no hazard.
- Captured operands are final. Later WB writes do not update a held output.
- rs1==rs2 with both used: both resolve identically, and hz is evaluated once.

Decomposition:
- Shared package cpu_pkg holds:
  - WORD_SIZE, INDEX_WIDTH, OP_WIDTH, IMM_WIDTH constants
  - decoded-instruction struct typedef (op, imm, rs1, rs2, use1, use2, rd, wr)
  - bypass-source typedef (valid, wrtEn, regno, data)
- One sub-module, bypass_mux: combinational EX/WB/RF priority select for a single operand. Instantiated twice.

Test Plan:
- Reset: hold reset=0, drive in_valid=1 → out_valid=0, out_a=0; after release, first accept gives out_valid=1 next edge.
- Plain read: rs1=3, rs2=5, rf_data=0x11/0x22, no bypass → out_a=0x11, out_b=0x22, one cycle after accept.
- Priority: rs1=7 with ex(rd=7, result=0xAAAA, !load) and wb(rd=7, data=0xBBBB) → out_a=0xAAAA. Remove ex → out_a=0xBBBB, even though rf_data1=0.
- Load-use: ex(rd=4, is_load=1), in rs2=4, use2=1 → in_ready=0, out_valid=0 next edge. Drop ex_is_load with wb(rd=4, data=0x55) → accepted, out_b=0x55. Same case with use2=0 → no stall.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with changing inputs → outputs unchanged, in_ready=0. Raise out_ready → next instruction loaded.
- Flush with in_valid=1, in_ready=1 → out_valid=0 next edge. Async reset asserted mid-hold → out_valid=0 immediately, without waiting for a clk edge.
